password_checker: RTL and testbench

PASSWORD_CHECKER -- requirements
Module: password_checker

---
 rtl/password_checker.sv | 172 +++++++++++++++++
 tb/tb_password_checker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/password_checker.sv
// Keypad password checker: collects 2-bit digits, checks them against CODE
// on Enter, opens for OPEN_CYCLES on a match and locks out for LOCK_CYCLES
// after MAX_FAIL consecutive failures.
// Optional feature: define PWCHK_TIMEOUT_EN to discard a partial entry after
// IDLE_CYCLES cycles without any key, Enter or Clear pulse.
module password_checker #(
  parameter int unsigned             CODE_LEN    = 4,
  parameter logic [2*CODE_LEN-1:0]   CODE        = 8'b01_11_00_10,
  parameter int unsigned             MAX_FAIL    = 3,
  parameter int unsigned             OPEN_CYCLES = 50,
  parameter int unsigned             LOCK_CYCLES = 200,
  parameter int unsigned             IDLE_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_pulse,
  input  logic       enter_pulse,
  input  logic       clear_pulse,
  output logic       unlocked,
  output logic       locked_out,
  output logic [1:0] fail_cnt,
  output logic [2:0] digit_cnt
);

  localparam int unsigned CODE_W  = 2 * CODE_LEN;
  localparam int unsigned TMR_MAX0 = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int unsigned TMR_MAX  = (TMR_MAX0 > IDLE_CYCLES) ? TMR_MAX0 : IDLE_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [1:0] S_ENTRY   = 2'd0;
  localparam logic [1:0] S_OPEN    = 2'd1;
  localparam logic [1:0] S_LOCKOUT = 2'd2;

  logic [1:0]        state_q,     state_d;
  logic [TMR_W-1:0]  timer_q,     timer_d;
  logic [CODE_W-1:0] digits_q,    digits_d;
  logic [2:0]        digit_cnt_q, digit_cnt_d;
  logic              err_q,       err_d;
  logic [1:0]        fail_q,      fail_d;
  logic              unlocked_q,  unlocked_d;
  logic              locked_q,    locked_d;

  logic              key_valid_c;
  logic              key_multi_c;
  logic [1:0]        key_digit_c;
  logic              pass_c;
  logic [2:0]        fail_inc_c;

  // Classify the key pulse: exactly one bit set is a digit, more is an error
  always_comb begin
    key_valid_c = (key_pulse != 4'd0) && ((key_pulse & (key_pulse - 4'd1)) == 4'd0);
    key_multi_c = (key_pulse != 4'd0) && !key_valid_c;
    case (key_pulse)
      4'b0010: key_digit_c = 2'd1;
      4'b0100: key_digit_c = 2'd2;
      4'b1000: key_digit_c = 2'd3;
      default: key_digit_c = 2'd0;
    endcase
  end

  assign pass_c     = (digit_cnt_q == 3'(CODE_LEN)) && !err_q && (digits_q == CODE);
  assign fail_inc_c = {1'b0, fail_q} + 3'd1;

  // Next-state and datapath update; the timer doubles as the idle counter in ENTRY
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    digits_d    = digits_q;
    digit_cnt_d = digit_cnt_q;
    err_d       = err_q;
    fail_d      = fail_q;
    case (state_q)
      S_ENTRY: begin
        if (clear_pulse) begin
          digit_cnt_d = 3'd0;
          err_d       = 1'b0;
        end else if (enter_pulse) begin
          digit_cnt_d = 3'd0;
          err_d       = 1'b0;
          timer_d     = '0;
          if (pass_c) begin
            state_d = S_OPEN;
            fail_d  = 2'd0;
          end else begin
            fail_d = fail_inc_c[1:0];
            if (fail_inc_c == 3'(MAX_FAIL)) begin
              state_d = S_LOCKOUT;
            end
          end
        end else if (key_multi_c) begin
          err_d = 1'b1;
        end else if (key_valid_c) begin
          if (digit_cnt_q < 3'(CODE_LEN)) begin
            for (int unsigned i = 0; i < CODE_LEN; i++) begin
              if (digit_cnt_q == 3'(i)) begin
                digits_d[2*(CODE_LEN-1-i) +: 2] = key_digit_c;
              end
            end
            digit_cnt_d = digit_cnt_q + 3'd1;
          end else begin
            err_d = 1'b1;
          end
        end
`ifdef PWCHK_TIMEOUT_EN
        if (!enter_pulse) begin
          if (clear_pulse || (key_pulse != 4'd0) || (digit_cnt_q == 3'd0)) begin
            timer_d = '0;
          end else if (timer_q == TMR_W'(IDLE_CYCLES - 1)) begin
            timer_d     = '0;
            digit_cnt_d = 3'd0;
            err_d       = 1'b0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
`endif
      end
      S_OPEN: begin
        if (timer_q == TMR_W'(OPEN_CYCLES - 1)) begin
          state_d = S_ENTRY;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_LOCKOUT: begin
        if (timer_q == TMR_W'(LOCK_CYCLES - 1)) begin
          state_d = S_ENTRY;
          timer_d = '0;
          fail_d  = 2'd0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = S_ENTRY;
        timer_d = '0;
      end
    endcase
    unlocked_d = (state_d == S_OPEN);
    locked_d   = (state_d == S_LOCKOUT);
  end

  // State and output registers, cleared asynchronously by rst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_ENTRY;
      timer_q     <= '0;
      digits_q    <= '0;
      digit_cnt_q <= 3'd0;
      err_q       <= 1'b0;
      fail_q      <= 2'd0;
      unlocked_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      digits_q    <= digits_d;
      digit_cnt_q <= digit_cnt_d;
      err_q       <= err_d;
      fail_q      <= fail_d;
      unlocked_q  <= unlocked_d;
      locked_q    <= locked_d;
    end
  end

  assign unlocked   = unlocked_q;
  assign locked_out = locked_q;
  assign fail_cnt   = fail_q;
  assign digit_cnt  = digit_cnt_q;

endmodule

// File: tb/tb_password_checker.sv
// Directed bench for password_checker (default parameters, code 1,3,0,2).
module tb_password_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_pulse = 4'd0;
  logic       enter_pulse = 1'b0;
  logic       clear_pulse = 1'b0;
  logic       unlocked;
  logic       locked_out;
  logic [1:0] fail_cnt;
  logic [2:0] digit_cnt;

  int checks = 0;
  int failures = 0;

  password_checker dut (
    .clk        (clk),
    .rst        (rst),
    .key_pulse  (key_pulse),
    .enter_pulse(enter_pulse),
    .clear_pulse(clear_pulse),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .fail_cnt   (fail_cnt),
    .digit_cnt  (digit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int d);
    key_pulse = 4'd1 << d;
    tick();
    key_pulse = 4'd0;
  endtask

  task automatic enter();
    enter_pulse = 1'b1;
    tick();
    enter_pulse = 1'b0;
  endtask

  task automatic code_ok();
    press(1); press(3); press(0); press(2);
  endtask

  task automatic wait_open(output int n);
    n = 0;
    while (unlocked && n < 1000) begin
      n++;
      tick();
    end
  endtask

  task automatic wrong_1111();
    press(1); press(1); press(1); press(1);
    enter();
  endtask

  int n;
  logic saw_unl;

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_unlocked", 32'(unlocked), 0);
    chk("rst_locked", 32'(locked_out), 0);
    chk("rst_fail", 32'(fail_cnt), 0);
    chk("rst_digit", 32'(digit_cnt), 0);
    rst = 1'b1;

    // Correct code opens for exactly 50 cycles
    code_ok();
    chk("ok_digit4", 32'(digit_cnt), 4);
    enter();
    chk("ok_unlocked", 32'(unlocked), 1);
    chk("ok_fail0", 32'(fail_cnt), 0);
    chk("ok_digit0", 32'(digit_cnt), 0);
    wait_open(n);
    chk("ok_open_len", 32'(n), 50);

    // Short code fails
    press(1); press(3); press(0);
    enter();
    chk("short_fail", 32'(fail_cnt), 1);
    chk("short_unl", 32'(unlocked), 0);
    chk("short_digit", 32'(digit_cnt), 0);

    // Clear wins over Enter in the same cycle
    press(1);
    clear_pulse = 1'b1; enter_pulse = 1'b1;
    tick();
    clear_pulse = 1'b0; enter_pulse = 1'b0;
    chk("clr_digit", 32'(digit_cnt), 0);
    chk("clr_fail", 32'(fail_cnt), 1);

    // Multi-bit key poisons the attempt without counting a digit
    key_pulse = 4'b0011;
    tick();
    key_pulse = 4'd0;
    chk("multi_digit", 32'(digit_cnt), 0);
    code_ok();
    enter();
    chk("multi_fail", 32'(fail_cnt), 2);
    chk("multi_unl", 32'(unlocked), 0);

    // A pass clears fail_cnt
    code_ok();
    enter();
    chk("pass_clr_fail", 32'(fail_cnt), 0);
    wait_open(n);

    // Fifth digit: count saturates, attempt fails
    press(1); press(3); press(0); press(2); press(2);
    chk("sat_digit", 32'(digit_cnt), 4);
    enter();
    chk("extra_fail", 32'(fail_cnt), 1);
    chk("extra_unl", 32'(unlocked), 0);
    code_ok();
    enter();
    wait_open(n);

    // Three wrong entries lock out for 200 cycles; code during lockout ignored
    wrong_1111();
    wrong_1111();
    chk("lk_fail2", 32'(fail_cnt), 2);
    chk("lk_not_yet", 32'(locked_out), 0);
    wrong_1111();
    chk("lk_locked", 32'(locked_out), 1);
    chk("lk_unl", 32'(unlocked), 0);
    n = 0;
    saw_unl = 1'b0;
    while (locked_out && n < 1000) begin
      n++;
      case (n)
        5: key_pulse = 4'b0010;
        6: key_pulse = 4'b1000;
        7: key_pulse = 4'b0001;
        8: key_pulse = 4'b0100;
        9: enter_pulse = 1'b1;
        default: ;
      endcase
      tick();
      key_pulse = 4'd0;
      enter_pulse = 1'b0;
      if (unlocked) saw_unl = 1'b1;
    end
    chk("lk_len", 32'(n), 200);
    chk("lk_ignored", 32'(saw_unl), 0);
    chk("lk_fail_after", 32'(fail_cnt), 0);
    chk("lk_digit_after", 32'(digit_cnt), 0);

    // Reset 10 cycles into OPEN aborts it at once
    code_ok();
    enter();
    repeat (10) tick();
    chk("rst_open_pre", 32'(unlocked), 1);
    rst = 1'b0;
    #1;
    chk("rst_open_abort", 32'(unlocked), 0);
    tick();
    tick();
    rst = 1'b1;
    code_ok();
    enter();
    chk("rst_reopen", 32'(unlocked), 1);
    wait_open(n);
    chk("rst_reopen_len", 32'(n), 50);

    // Inactivity behaviour on a partial entry
    press(1); press(3);
`ifdef PWCHK_TIMEOUT_EN
    repeat (99) tick();
    chk("idle_99", 32'(digit_cnt), 2);
    tick();
    chk("idle_100", 32'(digit_cnt), 0);
    press(0); press(2);
    enter();
    chk("idle_fail", 32'(fail_cnt), 1);
    chk("idle_unl", 32'(unlocked), 0);
`else
    repeat (150) tick();
    chk("hold_digit", 32'(digit_cnt), 2);
    press(0); press(2);
    enter();
    chk("hold_unl", 32'(unlocked), 1);
    chk("hold_fail", 32'(fail_cnt), 0);
    wait_open(n);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
